jtvigil_obj_linebuf: RTL and testbench
======================================

Name: jtvigil_obj_linebuf

Overview:
- Double (ping-pong) object line buffer for the Vigilante sprite path.
- Receives the pixel write stream from the object draw engine: palette+colour bytes with a 9-bit line address and a write strobe.
- Plays the previous line back to the video mixer at pixel rate, clearing each location as it is read.
- Banks swap every line, so the engine draws line N+1 while line N is displayed.

Parameters:
ALPHA, 4'h0, transparent colour index; writes with wr_data[3:0]==ALPHA are dropped
DW, 8, pixel word width ({pal[3:0], colour[3:0]})
AW, 9, line address width; each bank holds 2**AW words

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
LHBL  in  1  horizontal blank, active low
flip  in  1  screen flip; mirrors the read address
wr_data  in  DW  pixel from draw engine
wr_addr  in  AW  line position of wr_data
we  in  1  write strobe, one pixel per cycle
rd_addr  in  AW  display h counter
rd  in  1  pixel clock enable for read/erase
rd_data  out  DW  pixel to mixer
init_busy  out  1  high while post-reset clear sweep runs

Behaviour:
- State: bank select sel; LHBL_l; init counter icnt[AW-1:0]; erase pipeline er_v, er_addr, er_bank; rd_data register.
- Reset values: sel=0, LHBL_l=0, icnt=0, init_busy=1, er_v=0, rd_data=0.
- FSM has two states, INIT and RUN.
- INIT:
  - Each cycle, write 0 to address icnt in both banks, then icnt++.
  - When icnt==2**AW-1 is written, go to RUN next cycle and drop init_busy.
  - Duration is exactly 2**AW cycles (512 by default).
  - During INIT: we is ignored, rd is ignored, rd_data holds 0, sel does not toggle.
- Reset asserted mid-operation restarts INIT from icnt=0. Any pending erase is discarded.
- RUN, every cycle:
  - LHBL_l<=LHBL.
  - On LHBL falling edge (LHBL_l=1, LHBL=0), sel<=~sel.
- Write (RUN):
  - Condition: we=1 and wr_data[3:0]!=ALPHA.
  - Action: bank[sel][wr_addr]<=wr_data in the same cycle.
  - A write in the swap cycle uses the pre-swap sel.
  - Back-to-back writes are accepted every cycle, with no backpressure.
  - Address wrap is native AW-bit wrap: 0x1FF+1 lands at 0x000, and the engine relies on this.
  - Later writes to the same address overwrite earlier ones; the last writer wins.
- Read (RUN, rd=1):
  - Effective address ra = flip ? ~rd_addr : rd_addr.
  - rd_data <= bank[~sel][ra], valid the cycle after rd. Latency is 1 clk.
  - Same cycle: er_v<=1, er_addr<=ra, er_bank<=~sel.
  - rd=0: rd_data holds its value and er_v<=0.
- Erase:
  - When er_v=1, bank[er_bank][er_addr]<=0.
  - er_bank is captured at read time, so an erase in the swap cycle still hits the displayed bank.
- Port conflicts:
  - Writer and eraser normally target different banks.
  - If both hit the same bank and address in one cycle (a swap race), the writer wins.
- Read-during-erase on the same address returns the pre-erase data (read-before-write).
- Reading an unwritten or erased location returns 0.

Test Plan:
- Reset held 3 clks then released -> init_busy=1 for exactly 512 clks, then 0. rd during INIT gives rd_data=0. Any address reads 0 afterwards.
- Pixel write: write 8'h35 @0x123 and 8'h40 @0x124 (transparent), then LHBL fall. rd with rd_addr=0x123 -> rd_data=8'h35 one clk later. rd_addr=0x124 -> 8'h00.
- Erase: after the previous read, two more LHBL falls (bank returns to display) -> read of 0x123 gives 8'h00.
- Flip: write 8'h27 @0x010, swap, flip=1, rd_addr=0x1EF -> rd_data=8'h27. rd_addr=0x010 -> 8'h00.
- Swap race: we=1 (8'h51 @0x050) in the same clk as the LHBL falling edge, while rd erases 0x050 of the other bank -> next line reads 8'h51 @0x050. The old bank location reads 0.
- Wrap: engine writes 16 consecutive pixels (colour 1..F) starting 0x1F8 -> after swap, addresses 0x1F8..0x1FF and 0x000..0x007 return them in order. Mid-stream rst -> all reads return 0 after the 512-clk INIT.

Source files
------------

// File: rtl/jtvigil_obj_linebuf.sv
// rtl/jtvigil_obj_linebuf.sv - ping-pong object line buffer with erase-on-read and post-reset clear
module jtvigil_obj_linebuf #(
    parameter logic [3:0] ALPHA = 4'h0,
    parameter int         DW    = 8,
    parameter int         AW    = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          LHBL,
    input  logic          flip,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] wr_addr,
    input  logic          we,
    input  logic [AW-1:0] rd_addr,
    input  logic          rd,
    output logic [DW-1:0] rd_data,
    output logic          init_busy
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic {INIT, RUN} state_t;

    state_t        state_q, state_d;
    logic          sel_q, sel_d;
    logic          lhbl_l_q, lhbl_l_d;
    logic [AW-1:0] icnt_q, icnt_d;
    logic          er_v_q, er_v_d;
    logic [AW-1:0] er_addr_q, er_addr_d;
    logic          er_bank_q, er_bank_d;
    logic [DW-1:0] rd_data_q, rd_data_d;

    logic          wr_en;
    logic [AW-1:0] ra;

    logic [DW-1:0] bank0 [DEPTH];
    logic [DW-1:0] bank1 [DEPTH];

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        lhbl_l_d  = lhbl_l_q;
        icnt_d    = icnt_q;
        er_v_d    = 1'b0;
        er_addr_d = er_addr_q;
        er_bank_d = er_bank_q;
        rd_data_d = rd_data_q;
        wr_en     = 1'b0;
        ra        = flip ? ~rd_addr : rd_addr;
        case (state_q)
            INIT: begin
                icnt_d    = icnt_q + 1'b1;
                rd_data_d = '0;
                if (icnt_q == '1) begin
                    state_d = RUN;
                end
            end
            default: begin
                lhbl_l_d = LHBL;
                if (lhbl_l_q && !LHBL) begin
                    sel_d = ~sel_q;
                end
                wr_en = we && (wr_data[3:0] != ALPHA);
                if (rd) begin
                    // Displayed bank is the one the engine is not drawing into.
                    rd_data_d = sel_q ? bank0[ra] : bank1[ra];
                    er_v_d    = 1'b1;
                    er_addr_d = ra;
                    er_bank_d = ~sel_q;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= INIT;
            sel_q     <= 1'b0;
            lhbl_l_q  <= 1'b0;
            icnt_q    <= '0;
            er_v_q    <= 1'b0;
            er_addr_q <= '0;
            er_bank_q <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            lhbl_l_q  <= lhbl_l_d;
            icnt_q    <= icnt_d;
            er_v_q    <= er_v_d;
            er_addr_q <= er_addr_d;
            er_bank_q <= er_bank_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Erase is issued before the pixel write so that a same-address collision keeps the pixel.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == INIT) begin
                bank0[icnt_q] <= '0;
                bank1[icnt_q] <= '0;
            end else begin
                if (er_v_q && !er_bank_q) bank0[er_addr_q] <= '0;
                if (er_v_q &&  er_bank_q) bank1[er_addr_q] <= '0;
                if (wr_en  && !sel_q)     bank0[wr_addr]   <= wr_data;
                if (wr_en  &&  sel_q)     bank1[wr_addr]   <= wr_data;
            end
        end
    end

    assign rd_data   = rd_data_q;
    assign init_busy = (state_q == INIT);

endmodule

// File: tb/tb_jtvigil_obj_linebuf.sv
// tb/tb_jtvigil_obj_linebuf.sv - scoreboard bench for the object line buffer
module tb_jtvigil_obj_linebuf;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       LHBL = 1'b0;
    logic       flip = 1'b0;
    logic [7:0] wr_data = '0;
    logic [8:0] wr_addr = '0;
    logic       we = 1'b0;
    logic [8:0] rd_addr = '0;
    logic       rd = 1'b0;
    logic [7:0] rd_data;
    logic       init_busy;

    int n_chk  = 0;
    int n_pass = 0;
    logic [7:0] exp_q [$];
    logic       rd_seen = 1'b0;

    jtvigil_obj_linebuf dut (
        .clk       (clk),
        .rst       (rst),
        .LHBL      (LHBL),
        .flip      (flip),
        .wr_data   (wr_data),
        .wr_addr   (wr_addr),
        .we        (we),
        .rd_addr   (rd_addr),
        .rd        (rd),
        .rd_data   (rd_data),
        .init_busy (init_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    always @(posedge clk) rd_seen <= rd && !rst;

    always @(negedge clk) begin
        if (rd_seen) begin
            if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
            else chk("rd_data", rd_data, exp_q.pop_front());
        end
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic wr_px(input logic [8:0] a, input logic [7:0] d);
        we = 1'b1; wr_addr = a; wr_data = d;
        tick();
        we = 1'b0;
    endtask

    task automatic rd_px(input logic [8:0] a, input logic [7:0] e);
        rd = 1'b1; rd_addr = a;
        exp_q.push_back(e);
        tick();
        rd = 1'b0;
    endtask

    task automatic swap;
        LHBL = 1'b1;
        tick();
        LHBL = 1'b0;
        tick();
    endtask

    task automatic wait_init(input string tag, input bit probe);
        int cnt = 0;
        while (init_busy && cnt < 2000) begin
            if (probe && cnt == 100) begin
                rd = 1'b1; rd_addr = 9'h123;
                exp_q.push_back(8'h00);
            end else begin
                rd = 1'b0;
            end
            cnt++;
            tick();
        end
        rd = 1'b0;
        chk(tag, cnt, 512);
    endtask

    initial begin
        tick();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_busy", init_busy, 1);
        wait_init("init_len", 1'b1);
        tick();
        chk("run_busy", init_busy, 0);
        for (int i = 0; i < 4; i++) rd_px(9'(i * 97 + 3), 8'h00);

        // bank 0 is drawn, then displayed after the swap
        wr_px(9'h123, 8'h35);
        wr_px(9'h124, 8'h40);
        swap();
        rd_px(9'h123, 8'h35);
        rd_px(9'h124, 8'h00);

        swap();
        swap();
        rd_px(9'h123, 8'h00);

        wr_px(9'h010, 8'h27);
        swap();
        flip = 1'b1;
        rd_px(9'h1EF, 8'h27);
        rd_px(9'h010, 8'h00);
        flip = 1'b0;

        // read one cycle before the fall: erase lands in the swap cycle with the write
        LHBL = 1'b1; rd = 1'b1; rd_addr = 9'h050;
        exp_q.push_back(8'h00);
        tick();
        rd = 1'b0; LHBL = 1'b0;
        we = 1'b1; wr_addr = 9'h050; wr_data = 8'h51;
        tick();
        we = 1'b0;
        rd_px(9'h050, 8'h51);
        swap();
        rd_px(9'h050, 8'h00);

        for (int i = 0; i < 16; i++) wr_px(9'(9'h1F8 + i), 8'hA0 | 8'((i % 15) + 1));
        swap();
        for (int i = 0; i < 16; i++) rd_px(9'(9'h1F8 + i), 8'hA0 | 8'((i % 15) + 1));

        for (int i = 0; i < 8; i++) wr_px(9'(9'h100 + i), 8'h70 | 8'(i + 1));
        we = 1'b1; wr_addr = 9'h108; wr_data = 8'h79;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0; we = 1'b0;
        wait_init("reinit_len", 1'b0);
        rd_px(9'h100, 8'h00);
        rd_px(9'h105, 8'h00);
        swap();
        rd_px(9'h100, 8'h00);
        rd_px(9'h107, 8'h00);
        rd_px(9'h1F8, 8'h00);

        repeat (3) tick();
        chk("sb_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
